// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared CSR addresses, cause codes, privilege levels and FSM states
//
// Purpose: common definitions for the trap sequencer and its cause encoder.
// Ports:   none (package).
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_U    = 4'd8;
  localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

  typedef logic [1:0] priv_t;
  localparam priv_t PRIV_U = 2'b00;
  localparam priv_t PRIV_M = 2'b11;

  typedef enum logic [1:0] {
    TVAL_ZERO,
    TVAL_INST,
    TVAL_PC
  } tval_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_EPC,
    ST_WR_CAUSE,
    ST_WR_TVAL,
    ST_WAIT_VEC,
    ST_RD_EPC,
    ST_WAIT_EPC,
    ST_REDIRECT
  } trap_state_t;

endpackage

// File: rtl/trap_sequencer_if.sv
// rtl/trap_sequencer_if.sv - decode event, CSR port, redirect and status signals of the trap sequencer
//
// Purpose: bundles every non-clock/reset signal of trap_sequencer.
// Modports:
//   master - the sequencer: consumes ev_* and csr_rdata; drives ev_ready, flush, busy,
//            csr_we/waddr/wdata, csr_re/raddr, redirect_valid/pc, priv, mstatus_mie/mpie/mpp
//   slave  - decode/CSR file/fetch side, directions reversed
interface trap_sequencer_if #(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12
);
  logic              ev_valid;
  logic              ev_ready;
  logic [XLEN-1:0]   ev_pc;
  logic [31:0]       ev_inst;
  logic              ev_illegal;
  logic              ev_ecall;
  logic              ev_ebreak;
  logic              ev_mret;
  logic              ev_sret;
  logic              flush;
  logic              busy;
  logic              csr_we;
  logic [CSR_AW-1:0] csr_waddr;
  logic [XLEN-1:0]   csr_wdata;
  logic              csr_re;
  logic [CSR_AW-1:0] csr_raddr;
  logic [XLEN-1:0]   csr_rdata;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic [1:0]        priv;
  logic              mstatus_mie;
  logic              mstatus_mpie;
  logic [1:0]        mstatus_mpp;

  modport master (
    input  ev_valid, ev_pc, ev_inst, ev_illegal, ev_ecall, ev_ebreak, ev_mret, ev_sret, csr_rdata,
    output ev_ready, flush, busy, csr_we, csr_waddr, csr_wdata, csr_re, csr_raddr,
           redirect_valid, redirect_pc, priv, mstatus_mie, mstatus_mpie, mstatus_mpp
  );

  modport slave (
    output ev_valid, ev_pc, ev_inst, ev_illegal, ev_ecall, ev_ebreak, ev_mret, ev_sret, csr_rdata,
    input  ev_ready, flush, busy, csr_we, csr_waddr, csr_wdata, csr_re, csr_raddr,
           redirect_valid, redirect_pc, priv, mstatus_mie, mstatus_mpie, mstatus_mpp
  );
endinterface

// File: rtl/trap_cause_encode.sv
// rtl/trap_cause_encode.sv - prioritised classification of decoder event flags
//
// Purpose: maps event flags plus current privilege to trap/return kind, cause code and mtval source.
// Ports:
//   i_illegal/i_ecall/i_ebreak/i_mret/i_sret - decoder flags
//   i_priv                                   - current privilege
//   o_is_trap, o_is_ret                      - event starts a trap entry / an mret
//   o_cause                                  - mcause code for a trap
//   o_tval_sel                               - mtval source for a trap
module trap_cause_encode
  import trap_pkg::*;
(
  input  logic       i_illegal,
  input  logic       i_ecall,
  input  logic       i_ebreak,
  input  logic       i_mret,
  input  logic       i_sret,
  input  priv_t      i_priv,
  output logic       o_is_trap,
  output logic       o_is_ret,
  output logic [3:0] o_cause,
  output tval_sel_t  o_tval_sel
);

  always_comb begin
    o_is_trap  = 1'b0;
    o_is_ret   = 1'b0;
    o_cause    = CAUSE_ILLEGAL;
    o_tval_sel = TVAL_ZERO;
    // No S-mode exists, so sret and an mret outside M-mode are illegal instructions.
    if (i_illegal || i_sret || (i_mret && (i_priv != PRIV_M))) begin
      o_is_trap  = 1'b1;
      o_cause    = CAUSE_ILLEGAL;
      o_tval_sel = TVAL_INST;
    end else if (i_ebreak) begin
      o_is_trap  = 1'b1;
      o_cause    = CAUSE_BREAKPOINT;
      o_tval_sel = TVAL_PC;
    end else if (i_ecall) begin
      o_is_trap  = 1'b1;
      o_cause    = (i_priv == PRIV_M) ? CAUSE_ECALL_M : CAUSE_ECALL_U;
      o_tval_sel = TVAL_ZERO;
    end else if (i_mret) begin
      o_is_ret   = 1'b1;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode trap entry / mret return sequencer
//
// Purpose: accepts one decoder event at a time, writes mepc/mcause[/mtval], reads mtvec or
//          mepc, then pulses a fetch redirect. Owns privilege and mstatus MIE/MPIE/MPP.
// Ports:
//   clk, rst - clock; synchronous active-high reset
//   io_bus   - trap_sequencer_if.master (event handshake, CSR write/read, redirect, status)
// Build option: TRAP_MTVAL_EN adds the mtval write state (trap redirect one cycle later).
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12
) (
  input  logic             clk,
  input  logic             rst,
  trap_sequencer_if.master io_bus
);

  trap_state_t       r_state, w_state_next;
  priv_t             r_priv, r_mpp;
  logic              r_mie, r_mpie;
  logic [XLEN-1:0]   r_pc, r_redirect_pc;
  logic [3:0]        r_cause;

  logic              w_is_trap, w_is_ret, w_accept;
  logic [3:0]        w_cause;
  tval_sel_t         w_tval_sel;
  logic              w_csr_we, w_csr_re;
  logic [CSR_AW-1:0] w_csr_waddr, w_csr_raddr;
  logic [XLEN-1:0]   w_csr_wdata;

  trap_cause_encode u_cause (
    .i_illegal (io_bus.ev_illegal),
    .i_ecall   (io_bus.ev_ecall),
    .i_ebreak  (io_bus.ev_ebreak),
    .i_mret    (io_bus.ev_mret),
    .i_sret    (io_bus.ev_sret),
    .i_priv    (r_priv),
    .o_is_trap (w_is_trap),
    .o_is_ret  (w_is_ret),
    .o_cause   (w_cause),
    .o_tval_sel(w_tval_sel)
  );

  // Held in reset the block takes nothing, so no flush can leak out of a reset cycle.
  assign w_accept = io_bus.ev_valid && (r_state == ST_IDLE) && !rst;

`ifdef TRAP_MTVAL_EN
  logic [XLEN-1:0] r_tval, w_tval;
  always_comb begin
    w_tval = '0;
    case (w_tval_sel)
      TVAL_INST: w_tval = XLEN'(io_bus.ev_inst);
      TVAL_PC:   w_tval = io_bus.ev_pc;
      default:   w_tval = '0;
    endcase
  end
`else
  logic w_unused_tval;
  assign w_unused_tval = ^{w_tval_sel, io_bus.ev_inst};
`endif

  always_comb begin
    w_state_next = r_state;
    w_csr_we     = 1'b0;
    w_csr_waddr  = '0;
    w_csr_wdata  = '0;
    w_csr_re     = 1'b0;
    w_csr_raddr  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_trap)     w_state_next = ST_WR_EPC;
        else if (w_accept && w_is_ret) w_state_next = ST_RD_EPC;
      end
      ST_WR_EPC: begin
        w_csr_we     = 1'b1;
        w_csr_waddr  = CSR_AW'(CSR_MEPC);
        w_csr_wdata  = r_pc;
        w_state_next = ST_WR_CAUSE;
      end
      ST_WR_CAUSE: begin
        w_csr_we     = 1'b1;
        w_csr_waddr  = CSR_AW'(CSR_MCAUSE);
        w_csr_wdata  = XLEN'(r_cause);
`ifdef TRAP_MTVAL_EN
        w_state_next = ST_WR_TVAL;
`else
        // Last write state: overlap the mtvec read with it.
        w_csr_re     = 1'b1;
        w_csr_raddr  = CSR_AW'(CSR_MTVEC);
        w_state_next = ST_WAIT_VEC;
`endif
      end
`ifdef TRAP_MTVAL_EN
      ST_WR_TVAL: begin
        w_csr_we     = 1'b1;
        w_csr_waddr  = CSR_AW'(CSR_MTVAL);
        w_csr_wdata  = r_tval;
        w_csr_re     = 1'b1;
        w_csr_raddr  = CSR_AW'(CSR_MTVEC);
        w_state_next = ST_WAIT_VEC;
      end
`endif
      ST_WAIT_VEC: w_state_next = ST_REDIRECT;
      ST_RD_EPC: begin
        w_csr_re     = 1'b1;
        w_csr_raddr  = CSR_AW'(CSR_MEPC);
        w_state_next = ST_WAIT_EPC;
      end
      ST_WAIT_EPC: w_state_next = ST_REDIRECT;
      ST_REDIRECT: w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_priv        <= PRIV_M;
      r_mie         <= 1'b0;
      r_mpie        <= 1'b0;
      r_mpp         <= PRIV_U;
      r_pc          <= '0;
      r_cause       <= '0;
      r_redirect_pc <= '0;
`ifdef TRAP_MTVAL_EN
      r_tval        <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_accept && w_is_trap) begin
        r_pc    <= io_bus.ev_pc;
        r_cause <= w_cause;
`ifdef TRAP_MTVAL_EN
        r_tval  <= w_tval;
`endif
        r_priv  <= PRIV_M;
        r_mpp   <= r_priv;
        r_mpie  <= r_mie;
        r_mie   <= 1'b0;
      end else if (w_accept && w_is_ret) begin
        r_priv  <= r_mpp;
        r_mie   <= r_mpie;
        r_mpie  <= 1'b1;
        r_mpp   <= PRIV_U;
      end
      // mtvec mode bits are ignored (direct mode only); mepc bit 0 is never a valid target.
      if (r_state == ST_WAIT_VEC) r_redirect_pc <= io_bus.csr_rdata & ~XLEN'(3);
      if (r_state == ST_WAIT_EPC) r_redirect_pc <= io_bus.csr_rdata & ~XLEN'(1);
    end
  end

  assign io_bus.ev_ready       = (r_state == ST_IDLE);
  assign io_bus.busy           = (r_state != ST_IDLE);
  assign io_bus.flush          = w_accept && (w_is_trap || w_is_ret);
  assign io_bus.csr_we         = w_csr_we;
  assign io_bus.csr_waddr      = w_csr_waddr;
  assign io_bus.csr_wdata      = w_csr_wdata;
  assign io_bus.csr_re         = w_csr_re;
  assign io_bus.csr_raddr      = w_csr_raddr;
  assign io_bus.redirect_valid = (r_state == ST_REDIRECT);
  assign io_bus.redirect_pc    = r_redirect_pc;
  assign io_bus.priv           = r_priv;
  assign io_bus.mstatus_mie    = r_mie;
  assign io_bus.mstatus_mpie   = r_mpie;
  assign io_bus.mstatus_mpp    = r_mpp;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - self-checking bench for trap_sequencer
module tb_trap_sequencer;

`ifdef TRAP_MTVAL_EN
  localparam int TLAT     = 5;
  localparam bit MTVAL_ON = 1'b1;
`else
  localparam int TLAT     = 4;
  localparam bit MTVAL_ON = 1'b0;
`endif

  typedef struct packed {
    bit        flush;
    bit        we;
    bit        re;
    bit        redir;
    bit [11:0] waddr;
    bit [11:0] raddr;
    bit [63:0] wdata;
    bit [63:0] rpc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trap_sequencer_if #(.XLEN(64), .CSR_AW(12)) bus ();

  trap_sequencer #(.XLEN(64), .CSR_AW(12)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // environment CSR file, written by the DUT or by preset requests
  logic [63:0] env_mtvec = '0, env_mepc = '0, env_mcause = '0, env_mtval = '0;
  bit          pre_req = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [63:0] pre_val = '0;

  always @(posedge clk) begin
    if (pre_req) begin
      case (pre_addr)
        12'h305: env_mtvec <= pre_val;
        12'h341: env_mepc  <= pre_val;
        12'h343: env_mtval <= pre_val;
        default: ;
      endcase
    end
    if (bus.csr_we) begin
      case (bus.csr_waddr)
        12'h341: env_mepc   <= bus.csr_wdata;
        12'h342: env_mcause <= bus.csr_wdata;
        12'h343: env_mtval  <= bus.csr_wdata;
        default: ;
      endcase
    end
    if (bus.csr_re) begin
      case (bus.csr_raddr)
        12'h305: bus.csr_rdata <= env_mtvec;
        12'h341: bus.csr_rdata <= env_mepc;
        default: bus.csr_rdata <= 64'hDEAD_BEEF_DEAD_BEEF;
      endcase
    end else begin
      bus.csr_rdata <= 64'h0123_4567_89AB_CDEF;
    end
  end

  // behavioural model: architectural state plus a per-cycle timeline of expected strobes
  exp_t        sched [4096];
  bit   [1:0]  m_priv = 2'd3, m_mpp = 2'd0;
  bit          m_mie = 1'b0, m_mpie = 1'b0;
  int          m_busy_until = -1;
  logic [63:0] m_mepc = '0, m_mtvec = '0, m_rpc = '0;

  // observations used by the literal checks
  int          last_flush_cyc = -1, prev_flush_cyc = -1, last_redir_cyc = -1, n_we = 0;
  logic [63:0] last_redir_pc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sched_trap(input bit [3:0] cause, input logic [63:0] tval, input logic [63:0] pc);
    sched[cyc].flush = 1'b1;
    sched[cyc+1].we = 1'b1; sched[cyc+1].waddr = 12'h341; sched[cyc+1].wdata = pc;
    sched[cyc+2].we = 1'b1; sched[cyc+2].waddr = 12'h342; sched[cyc+2].wdata = 64'(cause);
    if (MTVAL_ON) begin
      sched[cyc+3].we = 1'b1; sched[cyc+3].waddr = 12'h343; sched[cyc+3].wdata = tval;
      sched[cyc+3].re = 1'b1; sched[cyc+3].raddr = 12'h305;
    end else begin
      sched[cyc+2].re = 1'b1; sched[cyc+2].raddr = 12'h305;
    end
    sched[cyc+TLAT].redir = 1'b1;
    sched[cyc+TLAT].rpc   = m_mtvec & ~64'd3;
    m_busy_until = cyc + TLAT;
    m_mepc = pc;
    m_mpp  = m_priv;
    m_mpie = m_mie;
    m_mie  = 1'b0;
    m_priv = 2'd3;
  endtask

  task automatic sched_mret();
    sched[cyc].flush = 1'b1;
    sched[cyc+1].re = 1'b1; sched[cyc+1].raddr = 12'h341;
    sched[cyc+3].redir = 1'b1;
    sched[cyc+3].rpc   = m_mepc & ~64'd1;
    m_busy_until = cyc + 3;
    m_priv = m_mpp;
    m_mie  = m_mpie;
    m_mpie = 1'b1;
    m_mpp  = 2'd0;
  endtask

  task automatic model_and_compare();
    exp_t e;
    bit   exp_ready, acc;
    bit [1:0] p_priv, p_mpp;
    bit   p_mie, p_mpie;
    if (pre_req) begin
      if (pre_addr == 12'h305) m_mtvec = pre_val;
      if (pre_addr == 12'h341) m_mepc  = pre_val;
    end
    if (sched[cyc].redir) m_rpc = sched[cyc].rpc;
    exp_ready = (cyc > m_busy_until);
    acc = exp_ready && bus.ev_valid && !rst;
    p_priv = m_priv; p_mpp = m_mpp; p_mie = m_mie; p_mpie = m_mpie;
    if (acc) begin
      if (bus.ev_illegal || bus.ev_sret || (bus.ev_mret && m_priv != 2'd3))
        sched_trap(4'd2, {32'd0, bus.ev_inst}, bus.ev_pc);
      else if (bus.ev_ebreak)
        sched_trap(4'd3, bus.ev_pc, bus.ev_pc);
      else if (bus.ev_ecall)
        sched_trap((m_priv == 2'd3) ? 4'd11 : 4'd8, 64'd0, bus.ev_pc);
      else if (bus.ev_mret)
        sched_mret();
    end
    e = sched[cyc];
    if (chk_en) begin
      chk("ev_ready", bus.ev_ready, exp_ready);
      chk("busy", bus.busy, !exp_ready);
      chk("flush", bus.flush, e.flush);
      chk("csr_we", bus.csr_we, e.we);
      if (e.we) begin
        chk("csr_waddr", bus.csr_waddr, e.waddr);
        chk("csr_wdata", bus.csr_wdata, e.wdata);
      end
      chk("csr_re", bus.csr_re, e.re);
      if (e.re) chk("csr_raddr", bus.csr_raddr, e.raddr);
      chk("redirect_valid", bus.redirect_valid, e.redir);
      chk("redirect_pc", bus.redirect_pc, m_rpc);
      chk("priv", bus.priv, p_priv);
      chk("mie", bus.mstatus_mie, p_mie);
      chk("mpie", bus.mstatus_mpie, p_mpie);
      chk("mpp", bus.mstatus_mpp, p_mpp);
    end
    if (bus.flush) begin prev_flush_cyc = last_flush_cyc; last_flush_cyc = cyc; end
    if (bus.redirect_valid) begin last_redir_cyc = cyc; last_redir_pc = bus.redirect_pc; end
    if (bus.csr_we) n_we++;
    if (rst) begin
      for (int i = 1; i <= 8; i++) sched[cyc+i] = '0;
      m_busy_until = cyc;
      m_priv = 2'd3; m_mie = 1'b0; m_mpie = 1'b0; m_mpp = 2'd0; m_rpc = '0;
    end
  endtask

  // one clock cycle: inputs already set #1 after the posedge, compare at the negedge
  task automatic tick();
    @(negedge clk);
    model_and_compare();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_ev();
    bus.ev_valid = 1'b0; bus.ev_illegal = 1'b0; bus.ev_ecall = 1'b0;
    bus.ev_ebreak = 1'b0; bus.ev_mret = 1'b0; bus.ev_sret = 1'b0;
  endtask

  task automatic set_ev(input bit il, input bit ec, input bit eb, input bit mr, input bit sr,
                        input logic [63:0] pc, input logic [31:0] inst);
    bus.ev_valid = 1'b1; bus.ev_illegal = il; bus.ev_ecall = ec; bus.ev_ebreak = eb;
    bus.ev_mret = mr; bus.ev_sret = sr; bus.ev_pc = pc; bus.ev_inst = inst;
  endtask

  task automatic issue(input bit il, input bit ec, input bit eb, input bit mr, input bit sr,
                       input logic [63:0] pc, input logic [31:0] inst);
    int guard = 0;
    while (!(cyc > m_busy_until) && guard < 30) begin tick(); guard++; end
    if (guard >= 30) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: sequencer still busy after %0d cycles", guard);
    end
    set_ev(il, ec, eb, mr, sr, pc, inst);
    tick();
    clear_ev();
    run(TLAT + 2);
  endtask

  task automatic preset(input logic [11:0] addr, input logic [63:0] val);
    pre_addr = addr; pre_val = val; pre_req = 1'b1;
    tick();
    pre_req = 1'b0;
  endtask

  initial begin
    int snap;
    clear_ev();
    bus.ev_pc = '0; bus.ev_inst = '0;
    @(posedge clk); #1;
    run(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset priv", bus.priv, 2'd3);
    chk("reset mie", bus.mstatus_mie, 1'b0);
    chk("reset mpie", bus.mstatus_mpie, 1'b0);
    chk("reset mpp", bus.mstatus_mpp, 2'd0);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset ev_ready", bus.ev_ready, 1'b1);
    chk("reset redirect_pc", bus.redirect_pc, 64'd0);
    chk("reset csr_we", bus.csr_we, 1'b0);

    preset(12'h305, 64'h8000_0004);
    preset(12'h343, 64'h5A5A);

    // ecall from M
    issue(0, 1, 0, 0, 0, 64'h8000_0100, 32'h0000_0073);
    chk("ecall_m mepc", env_mepc, 64'h8000_0100);
    chk("ecall_m mcause", env_mcause, 64'd11);
    chk("ecall_m redirect pc", last_redir_pc, 64'h8000_0004);
    chk("ecall_m redirect latency", 64'(last_redir_cyc - last_flush_cyc), 64'(TLAT));
    chk("ecall_m mpp", bus.mstatus_mpp, 2'd3);
    chk("ecall_m mtval", env_mtval, MTVAL_ON ? 64'd0 : 64'h5A5A);

    // mret back to M (mpp=3), then mret to U with mpie=1
    issue(0, 0, 0, 1, 0, 64'h8000_0104, 32'h3020_0073);
    chk("mret1 redirect pc", last_redir_pc, 64'h8000_0100);
    chk("mret1 mpie", bus.mstatus_mpie, 1'b1);
    preset(12'h341, 64'h8000_0201);
    issue(0, 0, 0, 1, 0, 64'h8000_0108, 32'h3020_0073);
    chk("mret2 redirect pc", last_redir_pc, 64'h8000_0200);
    chk("mret2 latency", 64'(last_redir_cyc - last_flush_cyc), 64'd3);
    chk("mret2 priv", bus.priv, 2'd0);
    chk("mret2 mie", bus.mstatus_mie, 1'b1);

    // ecall from U with mie=1
    issue(0, 1, 0, 0, 0, 64'h0000_1000, 32'h0000_0073);
    chk("ecall_u mcause", env_mcause, 64'd8);
    chk("ecall_u mpp", bus.mstatus_mpp, 2'd0);
    chk("ecall_u mie", bus.mstatus_mie, 1'b0);
    chk("ecall_u mpie", bus.mstatus_mpie, 1'b1);

    // illegal instruction
    preset(12'h343, 64'h5A5A);
    issue(1, 0, 0, 0, 0, 64'h8000_0300, 32'hFFFF_FFFF);
    chk("illegal mcause", env_mcause, 64'd2);
    chk("illegal mtval", env_mtval, MTVAL_ON ? 64'hFFFF_FFFF : 64'h5A5A);

    // ebreak with mtvec mode bits set
    preset(12'h305, 64'h8000_0007);
    issue(0, 0, 1, 0, 0, 64'h8000_0400, 32'h0010_0073);
    chk("ebreak mcause", env_mcause, 64'd3);
    chk("ebreak redirect pc", last_redir_pc, 64'h8000_0004);
    chk("ebreak mtval", env_mtval, MTVAL_ON ? 64'h8000_0400 : 64'h5A5A);

    // sret is always illegal
    issue(0, 0, 0, 0, 1, 64'h8000_0500, 32'h1020_0073);
    chk("sret mcause", env_mcause, 64'd2);

    // reach U-mode, then mret from U is illegal
    preset(12'h341, 64'h9000_0000);
    issue(0, 0, 0, 1, 0, 64'h8000_0600, 32'h3020_0073);
    issue(0, 0, 0, 1, 0, 64'h9000_0000, 32'h3020_0073);
    chk("to_u priv", bus.priv, 2'd0);
    issue(0, 0, 0, 1, 0, 64'h9000_0010, 32'h3020_0073);
    chk("mret_u mcause", env_mcause, 64'd2);
    chk("mret_u mepc", env_mepc, 64'h9000_0010);
    chk("mret_u mpp", bus.mstatus_mpp, 2'd0);

    // flag priorities
    issue(1, 1, 0, 0, 0, 64'h8000_0700, 32'h0000_0000);
    chk("prio illegal>ecall", env_mcause, 64'd2);
    issue(0, 1, 1, 0, 0, 64'h8000_0704, 32'h0000_0000);
    chk("prio ebreak>ecall", env_mcause, 64'd3);
    issue(0, 1, 0, 1, 0, 64'h8000_0708, 32'h0000_0000);
    chk("prio ecall>mret", env_mcause, 64'd11);

    // valid with no flags: consumed, no flush
    snap = last_flush_cyc;
    issue(0, 0, 0, 0, 0, 64'h8000_0800, 32'h0000_0013);
    chk("noflag no flush", 64'(last_flush_cyc), 64'(snap));
    chk("noflag idle", bus.busy, 1'b0);

    // ev_valid held through a whole sequence
    set_ev(0, 1, 0, 0, 0, 64'h8000_0900, 32'h0000_0073);
    run(2 * TLAT + 4);
    clear_ev();
    run(TLAT + 2);
    chk("held second accept", 64'(last_flush_cyc - prev_flush_cyc), 64'(TLAT + 1));

    // reset in WR_CAUSE
    preset(12'h341, 64'h0);
    set_ev(0, 1, 0, 0, 0, 64'h8000_0A00, 32'h0000_0073);
    tick();
    clear_ev();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    snap = n_we;
    chk("rst busy", bus.busy, 1'b0);
    chk("rst priv", bus.priv, 2'd3);
    run(8);
    chk("rst no csr_we", 64'(n_we), 64'(snap));
    chk("rst no redirect", 64'(last_redir_cyc < cyc - 9), 64'd1);
    chk("rst mepc written", env_mepc, 64'h8000_0A00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
